// File: rtl/rat_recovery_ctrl.sv
// ============================================================================
// Module   : rat_recovery_ctrl
// Brief    : Rebuilds the speculative RAT from the RRAT after a flush, two
//            architectural registers per cycle, and otherwise forwards the
//            two rename lanes to the RAT write ports. Optional macro
//            RAT_RECOVERY_PERF_EN enables the completed-recovery counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rob_pkg;
    parameter int NUM_ARCH_REGS = 32;
    parameter int NUM_PHYS_REGS = 64;
endpackage

module rat_recovery_ctrl #(
    parameter int NUM_ARCH_REGS = rob_pkg::NUM_ARCH_REGS,
    parameter int NUM_PHYS_REGS = rob_pkg::NUM_PHYS_REGS,
    localparam int c_AW = $clog2(NUM_ARCH_REGS),
    localparam int c_PW = $clog2(NUM_PHYS_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_req_in,
    input  logic [1:0]            rename_valid_in,
    input  logic [1:0][c_AW-1:0]  rename_arch_in,
    input  logic [1:0][c_PW-1:0]  rename_phys_in,
    output logic                  rename_stall_out,
    output logic [1:0][c_AW-1:0]  rrat_rd_addr_out,
    input  logic [1:0][c_PW-1:0]  rrat_rd_data_in,
    output logic [1:0]            rat_wr_valid_out,
    output logic [1:0][c_AW-1:0]  rat_wr_addr_out,
    output logic [1:0][c_PW-1:0]  rat_wr_data_out,
    output logic                  recover_done_out,
    output logic [15:0]           recover_count_out
);

    localparam logic [c_AW-1:0] c_LAST_IDX = c_AW'(NUM_ARCH_REGS - 2);
    localparam logic [c_AW-1:0] c_ONE      = c_AW'(1);
    localparam logic [c_AW-1:0] c_TWO      = c_AW'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_AW-1:0] r_idx;
    logic [c_AW-1:0] w_idx_nxt;
    logic [c_AW-1:0] r_pend_idx;
    logic            r_pend_valid;
    logic            w_pend_valid_nxt;
    logic            w_done;

    // The pending register remembers which even/odd pair was read last cycle,
    // so the RRAT data returning now can be written to the right RAT entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_idx   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_idx   <= r_idx;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_pend_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_idx_nxt = '0;
                if (flush_req_in) begin
                    w_state_nxt = S_WALK;
                end
            end
            S_WALK: begin
                w_pend_valid_nxt = ~flush_req_in;
                if (flush_req_in) begin
                    w_state_nxt = S_WALK;
                    w_idx_nxt   = '0;
                end else if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = S_DRAIN;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt   = r_idx + c_TWO;
                end
            end
            S_DRAIN: begin
                w_idx_nxt   = '0;
                w_state_nxt = flush_req_in ? S_WALK : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        rename_stall_out = (r_state != S_IDLE) || flush_req_in;
        rrat_rd_addr_out = '0;
        rat_wr_valid_out = '0;
        rat_wr_addr_out  = '0;
        rat_wr_data_out  = '0;
        w_done           = 1'b0;

        if (r_state == S_WALK) begin
            rrat_rd_addr_out[0] = r_idx;
            rrat_rd_addr_out[1] = r_idx | c_ONE;
        end

        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (!flush_req_in) begin
                        rat_wr_valid_out = rename_valid_in;
                        rat_wr_addr_out  = rename_arch_in;
                        rat_wr_data_out  = rename_phys_in;
                        // Same-cycle WAW: the younger lane owns the entry.
                        if ((rename_valid_in == 2'b11) &&
                            (rename_arch_in[0] == rename_arch_in[1])) begin
                            rat_wr_valid_out[0] = 1'b0;
                        end
                    end
                end
                S_WALK, S_DRAIN: begin
                    if (r_pend_valid) begin
                        rat_wr_valid_out   = 2'b11;
                        rat_wr_addr_out[0] = r_pend_idx;
                        rat_wr_addr_out[1] = r_pend_idx | c_ONE;
                        rat_wr_data_out    = rrat_rd_data_in;
                    end
                    w_done = (r_state == S_DRAIN);
                end
                default: begin
                    w_done = 1'b0;
                end
            endcase
        end
    end

    assign recover_done_out = w_done;

`ifdef RAT_RECOVERY_PERF_EN
    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_done && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign recover_count_out = r_count;
`else
    assign recover_count_out = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rat_recovery_ctrl.sv
// ============================================================================
// Module   : tb_rat_recovery_ctrl
// Brief    : Directed self-checking bench for rat_recovery_ctrl (32 arch regs,
//            64 phys regs) with a one-cycle-latency RRAT returning arch+32.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rat_recovery_ctrl;

    logic             clk;
    logic             rst;
    logic             flush_req_in;
    logic [1:0]       rename_valid_in;
    logic [1:0][4:0]  rename_arch_in;
    logic [1:0][5:0]  rename_phys_in;
    logic             rename_stall_out;
    logic [1:0][4:0]  rrat_rd_addr_out;
    logic [1:0][5:0]  rrat_rd_data_in;
    logic [1:0]       rat_wr_valid_out;
    logic [1:0][4:0]  rat_wr_addr_out;
    logic [1:0][5:0]  rat_wr_data_out;
    logic             recover_done_out;
    logic [15:0]      recover_count_out;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    rat_recovery_ctrl #(
        .NUM_ARCH_REGS (32),
        .NUM_PHYS_REGS (64)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .flush_req_in      (flush_req_in),
        .rename_valid_in   (rename_valid_in),
        .rename_arch_in    (rename_arch_in),
        .rename_phys_in    (rename_phys_in),
        .rename_stall_out  (rename_stall_out),
        .rrat_rd_addr_out  (rrat_rd_addr_out),
        .rrat_rd_data_in   (rrat_rd_data_in),
        .rat_wr_valid_out  (rat_wr_valid_out),
        .rat_wr_addr_out   (rat_wr_addr_out),
        .rat_wr_data_out   (rat_wr_data_out),
        .recover_done_out  (recover_done_out),
        .recover_count_out (recover_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RRAT: registered read, contents are arch + 32
    always @(posedge clk) begin
        rrat_rd_data_in[0] <= 6'(rrat_rd_addr_out[0]) + 6'd32;
        rrat_rd_data_in[1] <= 6'(rrat_rd_addr_out[1]) + 6'd32;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // p: -1 idle, 1..16 walk position, 17 drain
    task automatic run_seq(input string name, input int f1, input int f2,
                           input int rst_at, input int ncyc, input logic [1:0] rv);
        int p = -1;
        for (int k = 0; k < ncyc; k++) begin
            logic        fl, rs, e_stall, e_done;
            logic [1:0]  e_valid;
            logic [31:0] e_rd, e_addr, e_data;
            fl = (k == f1) || (k == f2);
            rs = (k == rst_at);
            flush_req_in       = fl;
            rst                = rs;
            rename_valid_in    = rv;
            rename_arch_in[0]  = 5'd4;
            rename_arch_in[1]  = 5'd9;
            rename_phys_in[0]  = 6'd21;
            rename_phys_in[1]  = 6'd20;

            e_stall = (p >= 1) || fl;
            e_rd    = (p >= 1 && p <= 16) ? 32'(((2*p-1) << 5) | (2*p-2)) : 32'd0;
            e_addr  = 32'd0;
            e_data  = 32'd0;
            if (p == -1) begin
                e_valid = fl ? 2'b00 : rv;
                e_addr  = 32'((9 << 5) | 4);
                e_data  = 32'((20 << 6) | 21);
            end else if (p >= 2) begin
                e_valid = 2'b11;
                e_addr  = 32'(((2*p-3) << 5) | (2*p-4));
                e_data  = 32'(((2*p-3+32) << 6) | (2*p-4+32));
            end else begin
                e_valid = 2'b00;
            end
            e_done = (p == 17);
            if (rs) begin
                e_valid = 2'b00;
                e_done  = 1'b0;
            end

            @(negedge clk);
            chk($sformatf("%s stall k=%0d", name, k), 32'(rename_stall_out), 32'(e_stall));
            if (!rs)
                chk($sformatf("%s rd_addr k=%0d", name, k), 32'(rrat_rd_addr_out), e_rd);
            chk($sformatf("%s wr_valid k=%0d", name, k), 32'(rat_wr_valid_out), 32'(e_valid));
            if (e_valid == 2'b11) begin
                chk($sformatf("%s wr_addr k=%0d", name, k), 32'(rat_wr_addr_out), e_addr);
                chk($sformatf("%s wr_data k=%0d", name, k), 32'(rat_wr_data_out), e_data);
            end
            chk($sformatf("%s done k=%0d", name, k), 32'(recover_done_out), 32'(e_done));

            if (rs)                   p = -1;
            else if (fl)              p = 1;
            else if (p >= 1 && p < 17) p = p + 1;
            else if (p == 17)         p = -1;
            next_cycle();
        end
        flush_req_in    = 1'b0;
        rst             = 1'b0;
        rename_valid_in = 2'b00;
    endtask

    task automatic chk_count(input string tag, input int completed);
`ifdef RAT_RECOVERY_PERF_EN
        exp_cnt = completed;
`else
        exp_cnt = 0 * completed;
`endif
        chk(tag, 32'(recover_count_out), 32'(exp_cnt));
    endtask

    initial begin
        rst             = 1'b1;
        flush_req_in    = 1'b1;
        rename_valid_in = 2'b11;
        rename_arch_in  = '0;
        rename_phys_in  = '0;
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset wr_valid", 32'(rat_wr_valid_out), 32'd0);
            chk("reset done", 32'(recover_done_out), 32'd0);
            next_cycle();
        end
        rst          = 1'b0;
        flush_req_in = 1'b0;
        rename_valid_in = 2'b00;
        @(negedge clk);
        chk("post-reset stall", 32'(rename_stall_out), 32'd0);
        chk("post-reset rd_addr", 32'(rrat_rd_addr_out), 32'd0);
        chk("post-reset count", 32'(recover_count_out), 32'd0);
        next_cycle();

        // Idle pass-through
        rename_valid_in   = 2'b11;
        rename_arch_in[0] = 5'd3;  rename_phys_in[0] = 6'd40;
        rename_arch_in[1] = 5'd5;  rename_phys_in[1] = 6'd41;
        @(negedge clk);
        chk("pass valid", 32'(rat_wr_valid_out), 32'd3);
        chk("pass addr", 32'(rat_wr_addr_out), 32'((5 << 5) | 3));
        chk("pass data", 32'(rat_wr_data_out), 32'((41 << 6) | 40));
        chk("pass stall", 32'(rename_stall_out), 32'd0);
        next_cycle();

        // Lane conflict: younger lane wins
        rename_arch_in[0] = 5'd7;  rename_phys_in[0] = 6'd50;
        rename_arch_in[1] = 5'd7;  rename_phys_in[1] = 6'd51;
        @(negedge clk);
        chk("conflict valid", 32'(rat_wr_valid_out), 32'd2);
        chk("conflict addr1", 32'(rat_wr_addr_out[1]), 32'd7);
        chk("conflict data1", 32'(rat_wr_data_out[1]), 32'd51);
        next_cycle();

        // Single lane 0, same arch on idle lane 1 must not suppress it
        rename_valid_in = 2'b01;
        @(negedge clk);
        chk("lane0 only valid", 32'(rat_wr_valid_out), 32'd1);
        chk("lane0 only data0", 32'(rat_wr_data_out[0]), 32'd50);
        next_cycle();
        rename_valid_in = 2'b00;

        run_seq("full", 0, -1, -1, 20, 2'b11);
        chk_count("count after full", 1);
        run_seq("restart", 0, 5, -1, 25, 2'b11);
        chk_count("count after restart", 2);
        run_seq("rstmid", 0, -1, 8, 12, 2'b00);
        chk_count("count after rst", 0);
        for (int i = 0; i < 3; i++)
            run_seq("b2b", 0, -1, -1, 18, 2'b00);
        chk_count("count after 3", 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
